// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
// Shares the register file's single write port between the ALU and LSU
// writeback streams. Each requester owns a one-entry holding register, so
// its ready depends only on that register's occupancy, never on its valid.
// Grant selection is a pure function of registered state. Operand reads
// that target a pending destination, or that coincide with a write, are
// stalled.
//
// Handshake: a request transfers on a rising CLK edge where
// <side>_valid & <side>_ready are both 1. Ready is RST_N & ~holding.valid.
// Valid may rise or fall at any time; nothing observes it until that edge.
// A holding register that drains on an edge cannot accept on that same edge.
module rf_write_arbiter #(
  parameter int W = 8,
  parameter int D = 3
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         alu_valid,
  output logic         alu_ready,
  input  logic [D-1:0] alu_dest,
  input  logic [W-1:0] alu_data,
  input  logic         lsu_valid,
  output logic         lsu_ready,
  input  logic [D-1:0] lsu_dest,
  input  logic [W-1:0] lsu_data,
  input  logic         rd_req,
  input  logic [D-1:0] rd_addr_a,
  input  logic [D-1:0] rd_addr_b,
  output logic         rd_stall,
  output logic [D-1:0] rf_srcA,
  output logic [D-1:0] rf_srcB,
  output logic [W-1:0] rf_writeValue,
  output logic [1:0]   rf_RegWrite,
  output logic         busy
);

  // ALU holding register
  logic         hAValid;
  logic [D-1:0] hADest;
  logic [W-1:0] hAData;

  // LSU holding register
  logic         hLValid;
  logic [D-1:0] hLDest;
  logic [W-1:0] hLData;

  // Relative age of the two entries. ageA: hA accepted strictly before hL.
  // ageL: hL accepted strictly before hA. Both clear: same-edge accept.
  logic ageA;
  logic ageL;

  // Round-robin pointer for same-edge, different-destination ties.
  // 0 = ALU next, 1 = LSU next.
  logic rr;

  logic grantA;
  logic grantL;
  logic grantAny;
  logic ruleRr;
  logic accA;
  logic accL;
  logic hazard;

  // Handshake acceptance for both requesters
  always_comb begin
    alu_ready = RST_N & ~hAValid;
    lsu_ready = RST_N & ~hLValid;
    accA      = alu_valid & alu_ready;
    accL      = lsu_valid & lsu_ready;
  end

  // Grant selection from registered state only; no write while in reset so
  // pending entries are discarded rather than committed.
  always_comb begin
    grantA = 1'b0;
    grantL = 1'b0;
    ruleRr = 1'b0;
    if (RST_N) begin
      if (hAValid && !hLValid) begin
        grantA = 1'b1;
      end else if (!hAValid && hLValid) begin
        grantL = 1'b1;
      end else if (hAValid && hLValid) begin
        if (ageA) begin
          grantA = 1'b1;
        end else if (ageL) begin
          grantL = 1'b1;
        end else if (hADest == hLDest) begin
          // Same destination on the same edge: ALU first so the LSU value
          // is the one left in the register.
          grantA = 1'b1;
        end else begin
          ruleRr = 1'b1;
          if (rr) begin
            grantL = 1'b1;
          end else begin
            grantA = 1'b1;
          end
        end
      end
    end
    grantAny = grantA | grantL;
  end

  // ALU holding register: drain on grant, load on accept (never both)
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      hAValid <= 1'b0;
    end else if (grantA) begin
      hAValid <= 1'b0;
    end else if (accA) begin
      hAValid <= 1'b1;
      hADest  <= alu_dest;
      hAData  <= alu_data;
    end
  end

  // LSU holding register: drain on grant, load on accept (never both)
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      hLValid <= 1'b0;
    end else if (grantL) begin
      hLValid <= 1'b0;
    end else if (accL) begin
      hLValid <= 1'b1;
      hLDest  <= lsu_dest;
      hLData  <= lsu_data;
    end
  end

  // Age tracking: an accept while the other entry stays pending marks the
  // other entry as older; any drain makes the ordering meaningless.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ageA <= 1'b0;
      ageL <= 1'b0;
    end else begin
      if (accL) begin
        ageA <= hAValid & ~grantA;
      end else if (grantAny) begin
        ageA <= 1'b0;
      end
      if (accA) begin
        ageL <= hLValid & ~grantL;
      end else if (grantAny) begin
        ageL <= 1'b0;
      end
    end
  end

  // Round-robin pointer advances only on grants decided by the tie rule
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rr <= 1'b0;
    end else if (ruleRr) begin
      rr <= ~rr;
    end
  end

  // Read hazard: an operand address matches any pending destination
  always_comb begin
    hazard = 1'b0;
    if (hAValid && ((rd_addr_a == hADest) || (rd_addr_b == hADest))) begin
      hazard = 1'b1;
    end
    if (hLValid && ((rd_addr_a == hLDest) || (rd_addr_b == hLDest))) begin
      hazard = 1'b1;
    end
  end

  // Register-file port drive: the write borrows srcA during a grant cycle
  always_comb begin
    rf_RegWrite   = 2'b00;
    rf_srcA       = rd_addr_a;
    rf_srcB       = rd_addr_b;
    rf_writeValue = '0;
    if (grantA) begin
      rf_RegWrite   = 2'b01;
      rf_srcA       = hADest;
      rf_writeValue = hAData;
    end else if (grantL) begin
      rf_RegWrite   = 2'b01;
      rf_srcA       = hLDest;
      rf_writeValue = hLData;
    end
    busy     = hAValid | hLValid;
    rd_stall = rd_req & (grantAny | hazard);
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Testbench for rf_write_arbiter: directed scenarios plus randomized traffic
// checked against a timestamp-based reference model and a shadow register file.
module tb_rf_write_arbiter;
  localparam int W = 8;
  localparam int D = 3;

  logic         CLK;
  logic         RST_N;
  logic         alu_valid, lsu_valid, rd_req;
  logic         alu_ready, lsu_ready, rd_stall, busy;
  logic [D-1:0] alu_dest, lsu_dest, rd_addr_a, rd_addr_b, rf_srcA, rf_srcB;
  logic [W-1:0] alu_data, lsu_data, rf_writeValue;
  logic [1:0]   rf_RegWrite;

  int tests = 0;
  int fails = 0;

  // Shadow of the real register file, written from the DUT's rf_* outputs
  logic [W-1:0] dutRegs [8];

  // Reference model: pending writes carry the cycle number of their accept
  bit           mAV, mLV;
  logic [D-1:0] mAD, mLD;
  logic [W-1:0] mAX, mLX;
  int           mAS, mLS;
  bit           mRr;
  int           cyc;
  logic [W-1:0] mRegs [8];

  rf_write_arbiter #(.W(W), .D(D)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_dest(lsu_dest), .lsu_data(lsu_data),
    .rd_req(rd_req), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_stall(rd_stall),
    .rf_srcA(rf_srcA), .rf_srcB(rf_srcB), .rf_writeValue(rf_writeValue),
    .rf_RegWrite(rf_RegWrite), .busy(busy)
  );

  // Clock and shadow register file
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (rf_RegWrite == 2'b01) dutRegs[rf_srcA] <= rf_writeValue;
  end

  // Which pending write goes this cycle: 0 none, 1 ALU, 2 LSU
  function automatic int modelGrant();
    if (!RST_N) return 0;
    if (!mAV && !mLV) return 0;
    if (mAV && !mLV) return 1;
    if (mLV && !mAV) return 2;
    if (mAS < mLS) return 1;
    if (mLS < mAS) return 2;
    if (mAD == mLD) return 1;
    return mRr ? 2 : 1;
  endfunction

  // Driver: advance one clock, updating the model with the inputs held now
  task automatic advance();
    int g;
    bit tie, aAcc, lAcc, rstLow;
    logic [D-1:0] ad, ld;
    logic [W-1:0] ax, lx;
    g      = modelGrant();
    tie    = (g != 0) && mAV && mLV && (mAS == mLS) && (mAD != mLD);
    rstLow = !RST_N;
    aAcc   = alu_valid && RST_N && !mAV;
    lAcc   = lsu_valid && RST_N && !mLV;
    ad = alu_dest; ax = alu_data; ld = lsu_dest; lx = lsu_data;
    @(posedge CLK);
    cyc++;
    if (rstLow) begin
      mAV = 0; mLV = 0; mRr = 0;
    end else begin
      if (g == 1) begin mRegs[mAD] = mAX; mAV = 0; end
      if (g == 2) begin mRegs[mLD] = mLX; mLV = 0; end
      if (tie) mRr = !mRr;
      if (aAcc) begin mAV = 1; mAD = ad; mAX = ax; mAS = cyc; end
      if (lAcc) begin mLV = 1; mLD = ld; mLX = lx; mLS = cyc; end
    end
    @(negedge CLK);
  endtask

  task automatic setIdle();
    alu_valid = 0; alu_dest = '0; alu_data = '0;
    lsu_valid = 0; lsu_dest = '0; lsu_data = '0;
    rd_req = 0; rd_addr_a = '0; rd_addr_b = '0;
  endtask

  task automatic setAlu(input logic [D-1:0] d, input logic [W-1:0] x);
    alu_valid = 1; alu_dest = d; alu_data = x;
  endtask

  task automatic setLsu(input logic [D-1:0] d, input logic [W-1:0] x);
    lsu_valid = 1; lsu_dest = d; lsu_data = x;
  endtask

  task automatic doReset();
    setIdle();
    RST_N = 0;
    advance();
    RST_N = 1;
  endtask

  task automatic test_reset();
    setIdle();
    RST_N = 0; rd_req = 1; rd_addr_a = 3'd5; rd_addr_b = 3'd6;
    #1;
    tests++; if (alu_ready !== 1'b0) begin fails++; $display("FAIL rst_alu_ready_low got=%0b exp=0", alu_ready); end
    tests++; if (lsu_ready !== 1'b0) begin fails++; $display("FAIL rst_lsu_ready_low got=%0b exp=0", lsu_ready); end
    advance(); advance();
    RST_N = 1;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    tests++; if (rf_RegWrite !== 2'b00) begin fails++; $display("FAIL rst_regwrite got=%0b exp=0", rf_RegWrite); end
    tests++; if (rd_stall !== 1'b0) begin fails++; $display("FAIL rst_stall got=%0b exp=0", rd_stall); end
    tests++; if (rf_writeValue !== 8'h00) begin fails++; $display("FAIL rst_wv got=%0h exp=0", rf_writeValue); end
    tests++; if (rf_srcA !== 3'd5) begin fails++; $display("FAIL rst_srcA got=%0d exp=5", rf_srcA); end
    tests++; if (rf_srcB !== 3'd6) begin fails++; $display("FAIL rst_srcB got=%0d exp=6", rf_srcB); end
    tests++; if ({alu_ready, lsu_ready} !== 2'b11) begin fails++; $display("FAIL rst_ready_high got=%b exp=11", {alu_ready, lsu_ready}); end
  endtask

  task automatic test_alu_alone();
    doReset();
    setAlu(3'd3, 8'hAA);
    #1;
    tests++; if (alu_ready !== 1'b1) begin fails++; $display("FAIL alu_ready_pre got=%0b exp=1", alu_ready); end
    advance();
    setIdle();
    #1;
    tests++; if (alu_ready !== 1'b0) begin fails++; $display("FAIL alu_ready_held got=%0b exp=0", alu_ready); end
    tests++; if (rf_RegWrite !== 2'b01) begin fails++; $display("FAIL alu_regwrite got=%0b exp=1", rf_RegWrite); end
    tests++; if (rf_srcA !== 3'd3) begin fails++; $display("FAIL alu_srcA got=%0d exp=3", rf_srcA); end
    tests++; if (rf_writeValue !== 8'hAA) begin fails++; $display("FAIL alu_wv got=%0h exp=aa", rf_writeValue); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL alu_busy got=%0b exp=1", busy); end
    advance();
    #1;
    tests++; if (alu_ready !== 1'b1) begin fails++; $display("FAIL alu_ready_back got=%0b exp=1", alu_ready); end
    tests++; if (rf_RegWrite !== 2'b00) begin fails++; $display("FAIL alu_regwrite_off got=%0b exp=0", rf_RegWrite); end
    tests++; if (dutRegs[3] !== 8'hAA) begin fails++; $display("FAIL alu_reg3 got=%0h exp=aa", dutRegs[3]); end
  endtask

  task automatic test_pair_rr();
    doReset();
    setAlu(3'd1, 8'h11); setLsu(3'd2, 8'h22);
    advance();
    setIdle(); #1;
    tests++; if ({rf_RegWrite, rf_srcA, rf_writeValue} !== {2'b01, 3'd1, 8'h11}) begin fails++; $display("FAIL pair1_first got=%0d/%0d/%0h exp=1/1/11", rf_RegWrite, rf_srcA, rf_writeValue); end
    advance(); #1;
    tests++; if ({rf_RegWrite, rf_srcA, rf_writeValue} !== {2'b01, 3'd2, 8'h22}) begin fails++; $display("FAIL pair1_second got=%0d/%0d/%0h exp=1/2/22", rf_RegWrite, rf_srcA, rf_writeValue); end
    advance();
    setAlu(3'd1, 8'h11); setLsu(3'd2, 8'h22); #1;
    tests++; if ({alu_ready, lsu_ready} !== 2'b11) begin fails++; $display("FAIL pair_ready got=%b exp=11", {alu_ready, lsu_ready}); end
    advance();
    setIdle(); #1;
    tests++; if ({rf_RegWrite, rf_srcA, rf_writeValue} !== {2'b01, 3'd2, 8'h22}) begin fails++; $display("FAIL pair2_first got=%0d/%0d/%0h exp=1/2/22", rf_RegWrite, rf_srcA, rf_writeValue); end
    advance(); #1;
    tests++; if ({rf_RegWrite, rf_srcA, rf_writeValue} !== {2'b01, 3'd1, 8'h11}) begin fails++; $display("FAIL pair2_second got=%0d/%0d/%0h exp=1/1/11", rf_RegWrite, rf_srcA, rf_writeValue); end
    advance(); #1;
    tests++; if ({dutRegs[1], dutRegs[2]} !== {8'h11, 8'h22}) begin fails++; $display("FAIL pair_regs got=%0h/%0h exp=11/22", dutRegs[1], dutRegs[2]); end
  endtask

  task automatic test_same_dest();
    doReset();
    setAlu(3'd5, 8'h55); setLsu(3'd5, 8'h66);
    advance();
    setIdle(); #1;
    tests++; if ({rf_srcA, rf_writeValue} !== {3'd5, 8'h55}) begin fails++; $display("FAIL same_first got=%0d/%0h exp=5/55", rf_srcA, rf_writeValue); end
    advance(); #1;
    tests++; if ({rf_srcA, rf_writeValue} !== {3'd5, 8'h66}) begin fails++; $display("FAIL same_second got=%0d/%0h exp=5/66", rf_srcA, rf_writeValue); end
    advance(); #1;
    tests++; if (dutRegs[5] !== 8'h66) begin fails++; $display("FAIL same_reg5 got=%0h exp=66", dutRegs[5]); end
    // pointer untouched by the same-destination rule: ALU still goes first
    setAlu(3'd1, 8'h31); setLsu(3'd2, 8'h32);
    advance();
    setIdle(); #1;
    tests++; if (rf_srcA !== 3'd1) begin fails++; $display("FAIL same_rr_kept got=%0d exp=1", rf_srcA); end
    advance(); advance();
  endtask

  task automatic test_older();
    doReset();
    setLsu(3'd4, 8'h44);
    advance();
    setIdle(); setAlu(3'd0, 8'hA0); #1;
    tests++; if ({rf_RegWrite, rf_srcA, rf_writeValue} !== {2'b01, 3'd4, 8'h44}) begin fails++; $display("FAIL older_lsu got=%0d/%0d/%0h exp=1/4/44", rf_RegWrite, rf_srcA, rf_writeValue); end
    advance();
    setIdle(); #1;
    tests++; if ({rf_RegWrite, rf_srcA, rf_writeValue} !== {2'b01, 3'd0, 8'hA0}) begin fails++; $display("FAIL older_alu got=%0d/%0d/%0h exp=1/0/a0", rf_RegWrite, rf_srcA, rf_writeValue); end
    advance(); #1;
    tests++; if ({dutRegs[4], dutRegs[0]} !== {8'h44, 8'hA0}) begin fails++; $display("FAIL older_regs got=%0h/%0h exp=44/a0", dutRegs[4], dutRegs[0]); end
  endtask

  task automatic test_hazard();
    doReset();
    rd_req = 1; rd_addr_a = 3'd0; rd_addr_b = 3'd6;
    setAlu(3'd6, 8'h6E); #1;
    tests++; if (rd_stall !== 1'b0) begin fails++; $display("FAIL haz_idle got=%0b exp=0", rd_stall); end
    advance();
    alu_valid = 0; #1;
    tests++; if (rd_stall !== 1'b1) begin fails++; $display("FAIL haz_pending got=%0b exp=1", rd_stall); end
    advance(); #1;
    tests++; if (rd_stall !== 1'b0) begin fails++; $display("FAIL haz_drained got=%0b exp=0", rd_stall); end
    rd_addr_a = 3'd7; rd_addr_b = 3'd2; #1;
    tests++; if ({rd_stall, rf_srcA, rf_srcB} !== {1'b0, 3'd7, 3'd2}) begin fails++; $display("FAIL haz_free got=%0b/%0d/%0d exp=0/7/2", rd_stall, rf_srcA, rf_srcB); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] r1, r2;
    doReset();
    setAlu(3'd1, 8'hB1); setLsu(3'd2, 8'hB2);
    advance();
    setIdle();
    r1 = dutRegs[1]; r2 = dutRegs[2];
    RST_N = 0; #1;
    tests++; if (rf_RegWrite !== 2'b00) begin fails++; $display("FAIL mid_rw_in_reset got=%0b exp=0", rf_RegWrite); end
    advance();
    RST_N = 1; #1;
    tests++; if ({busy, rf_RegWrite} !== 3'b000) begin fails++; $display("FAIL mid_after got=%0b/%0b exp=0/0", busy, rf_RegWrite); end
    advance(); #1;
    tests++; if ({dutRegs[1], dutRegs[2]} !== {r1, r2}) begin fails++; $display("FAIL mid_regs got=%0h/%0h exp=%0h/%0h", dutRegs[1], dutRegs[2], r1, r2); end
    tests++; if ({alu_ready, lsu_ready} !== 2'b11) begin fails++; $display("FAIL mid_ready got=%b exp=11", {alu_ready, lsu_ready}); end
  endtask

  task automatic test_random();
    int g;
    bit hz;
    logic [D-1:0] eSrcA;
    logic [W-1:0] eWv;
    doReset();
    for (int i = 0; i < 600; i++) begin
      RST_N     = ($urandom_range(0, 59) != 0);
      alu_valid = $urandom_range(0, 2) != 0;
      alu_dest  = D'($urandom_range(0, 7));
      alu_data  = W'($urandom);
      lsu_valid = $urandom_range(0, 2) != 0;
      lsu_dest  = D'($urandom_range(0, 7));
      lsu_data  = W'($urandom);
      rd_req    = $urandom_range(0, 1);
      rd_addr_a = D'($urandom_range(0, 7));
      rd_addr_b = D'($urandom_range(0, 7));
      #1;
      g     = modelGrant();
      eSrcA = (g == 1) ? mAD : (g == 2) ? mLD : rd_addr_a;
      eWv   = (g == 1) ? mAX : (g == 2) ? mLX : '0;
      hz    = (mAV && (rd_addr_a == mAD || rd_addr_b == mAD)) ||
              (mLV && (rd_addr_a == mLD || rd_addr_b == mLD));
      tests++; if (alu_ready !== (RST_N && !mAV)) begin fails++; $display("FAIL rnd_alu_ready cyc=%0d got=%0b exp=%0b", cyc, alu_ready, RST_N && !mAV); end
      tests++; if (lsu_ready !== (RST_N && !mLV)) begin fails++; $display("FAIL rnd_lsu_ready cyc=%0d got=%0b exp=%0b", cyc, lsu_ready, RST_N && !mLV); end
      tests++; if (busy !== (mAV || mLV)) begin fails++; $display("FAIL rnd_busy cyc=%0d got=%0b exp=%0b", cyc, busy, mAV || mLV); end
      tests++; if (rf_RegWrite !== ((g != 0) ? 2'b01 : 2'b00)) begin fails++; $display("FAIL rnd_regwrite cyc=%0d got=%0b grant=%0d", cyc, rf_RegWrite, g); end
      tests++; if (rf_srcA !== eSrcA) begin fails++; $display("FAIL rnd_srcA cyc=%0d got=%0d exp=%0d", cyc, rf_srcA, eSrcA); end
      tests++; if (rf_srcB !== rd_addr_b) begin fails++; $display("FAIL rnd_srcB cyc=%0d got=%0d exp=%0d", cyc, rf_srcB, rd_addr_b); end
      tests++; if (rf_writeValue !== eWv) begin fails++; $display("FAIL rnd_wv cyc=%0d got=%0h exp=%0h", cyc, rf_writeValue, eWv); end
      tests++; if (rd_stall !== (rd_req && (g != 0 || hz))) begin fails++; $display("FAIL rnd_stall cyc=%0d got=%0b exp=%0b", cyc, rd_stall, rd_req && (g != 0 || hz)); end
      advance();
    end
    RST_N = 1; setIdle();
    advance(); advance(); advance();
  endtask

  task automatic test_regfile();
    #1;
    for (int r = 0; r < 8; r++) begin
      tests++; if (dutRegs[r] !== mRegs[r]) begin fails++; $display("FAIL regfile_r%0d got=%0h exp=%0h", r, dutRegs[r], mRegs[r]); end
    end
  endtask

  // Test sequence and final report
  initial begin
    for (int r = 0; r < 8; r++) begin
      dutRegs[r] = '0;
      mRegs[r]   = '0;
    end
    mAV = 0; mLV = 0; mRr = 0; mAS = 0; mLS = 0; cyc = 0;
    mAD = '0; mLD = '0; mAX = '0; mLX = '0;
    RST_N = 0;
    setIdle();
    @(negedge CLK);
    test_reset();
    test_alu_alone();
    test_pair_rr();
    test_same_dest();
    test_older();
    test_hazard();
    test_reset_mid();
    test_random();
    test_regfile();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
